sd_tx_scheduler: RTL and testbench

//  Shares the SD-card SPI byte transmitter between two byte-stream requesters.

---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_rr_arb2.sv | 23 ++
 rtl/sd_tx_scheduler.sv | 149 ++++++++++++++
 tb/tb_sd_tx_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI transmit path.
// Holds the scheduler FSM encoding, the SD byte width and the default byte pacing.
// Also provides a one-hot helper for the two-requester grant vector.
package sd_pkg;

  localparam int SD_BYTE_W          = 8;
  localparam int SD_BYTE_PERIOD_DEF = 96;

  // Scheduler FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef logic [SD_BYTE_W-1:0] sd_byte_t;

  // Requester index -> one-hot grant
  function automatic logic [1:0] sd_onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sd_rr_arb2.sv
// Purpose: 2-way round-robin picker. The requester named by ptr wins if it is
//   requesting, otherwise the other one does.
// Latency: purely combinational. Backpressure: none; the caller owns the pointer.
// Ports: req[1:0] request vector, ptr preferred requester, gnt[1:0] one-hot pick
//   (00 when nobody requests).
module sd_rr_arb2
  import sd_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[ptr]) begin
      gnt = sd_onehot2(ptr);
    end else if (req[~ptr]) begin
      gnt = sd_onehot2(~ptr);
    end
  end

endmodule

// File: rtl/sd_tx_scheduler.sv
// Purpose: shares one SPI byte shifter between two byte-stream requesters with
//   bursty round-robin grants and a minimum BYTE_PERIOD spacing between launches.
// Latency: idle request to tx_start is 2 cycles when pacing allows it.
// Backpressure: reqN_ready pulses for one cycle per accepted byte, only when the
//   requester owns the grant, the pacing window has expired and the shifter is idle.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/data/last/ready byte stream from requester N (N = 0, 1)
//   tx_start, tx_data          launch pulse and byte (held until tx_done)
//   tx_done                    shifter finished the current byte
//   grant                      one-hot current owner, 00 when idle
module sd_tx_scheduler
  import sd_pkg::*;
#(
  parameter int BYTE_PERIOD = SD_BYTE_PERIOD_DEF,
  parameter int CNT_W       = 17,
  parameter int BURST_MAX   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [SD_BYTE_W-1:0] req0_data,
  input  logic                 req0_last,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [SD_BYTE_W-1:0] req1_data,
  input  logic                 req1_last,
  output logic                 req1_ready,
  output logic                 tx_start,
  output logic [SD_BYTE_W-1:0] tx_data,
  input  logic                 tx_done,
  output logic [1:0]           grant
);

  localparam int              BC_W      = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] PACE_MAX  = CNT_W'(BYTE_PERIOD - 1);
  localparam logic [BC_W-1:0]  BURST_LIM = BC_W'(BURST_MAX);

  logic [1:0]       state_q;
  logic [1:0]       grant_q;
  logic             rr_q;      // preferred requester for the next idle pick
  logic [BC_W-1:0]  burst_q;
  logic [CNT_W-1:0] pace_q;
  sd_byte_t         data_q;
  logic             last_q;
  logic             start_q;

  logic [1:0]       arb_gnt;
  logic             g_valid;
  sd_byte_t         g_data;
  logic             g_last;
  logic             paced;
  logic             launch;

  sd_rr_arb2 u_arb (
    .req (({req1_valid, req0_valid})),
    .ptr (rr_q),
    .gnt (arb_gnt)
  );

  // Mux of the granted requester's stream; all zero when nobody owns the grant
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    if (grant_q[0]) begin
      g_valid = req0_valid;
      g_data  = req0_data;
      g_last  = req0_last;
    end else if (grant_q[1]) begin
      g_valid = req1_valid;
      g_data  = req1_data;
      g_last  = req1_last;
    end
  end

  assign paced  = (pace_q == PACE_MAX);
  assign launch = (state_q == ST_SEND) && g_valid && paced;

  // The accept handshake is this cycle; the launch pulse follows one cycle later
  assign req0_ready = launch && grant_q[0];
  assign req1_ready = launch && grant_q[1];

  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign grant    = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      burst_q <= '0;
      pace_q  <= PACE_MAX;   // first byte after reset goes out without waiting
      data_q  <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= launch;

      // Counter reads 0 in the tx_start cycle, so launches land exactly
      // BYTE_PERIOD cycles apart when the requester keeps up.
      if (launch) begin
        pace_q <= '0;
      end else if (!paced) begin
        pace_q <= pace_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (arb_gnt != 2'b00) begin
            grant_q <= arb_gnt;
            burst_q <= '0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!g_valid) begin
            // Owner went quiet mid-frame: hand the next turn to the other side
            grant_q <= 2'b00;
            rr_q    <= grant_q[0];
            state_q <= ST_IDLE;
          end else if (paced) begin
            data_q  <= g_data;
            last_q  <= g_last;
            burst_q <= burst_q + BC_W'(1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (last_q || (burst_q == BURST_LIM)) begin
              grant_q <= 2'b00;
              rr_q    <= grant_q[0];
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_SEND;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_tx_scheduler.sv
// Bench for sd_tx_scheduler: table of single-byte arbitration vectors plus
// hand-written sequences for pacing, bursts, reset mid-byte and owner drop-out.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_sd_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [1:0] grant;

  always #5 clk = ~clk;

  sd_tx_scheduler #(
    .BYTE_PERIOD (96),
    .CNT_W       (17),
    .BURST_MAX   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .grant      (grant)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int inv_bad = 0;
  int rdy0_cnt, rdy1_cnt;
  logic s_start, hs0, hs1;
  bit saw_idle;

  // Requester source models
  bit         src_on  [2];
  int         src_rem [2];
  int         src_flen[2];
  bit         src_rep [2];
  logic [7:0] src_data[2];

  // tx_done responder
  bit auto_en;
  int done_cnt;
  int done_del = 8;

  // Launch log
  int         st_cyc[$];
  logic [7:0] st_dat[$];
  logic [1:0] st_own[$];

  typedef struct {
    bit         v0;
    bit         v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    req0_valid = src_on[0] && (src_rem[0] != 0);
    req0_data  = src_data[0];
    req0_last  = (src_rem[0] == 1);
    req1_valid = src_on[1] && (src_rem[1] != 0);
    req1_data  = src_data[1];
    req1_last  = (src_rem[1] == 1);
  endtask

  task automatic src_frame(input int i, input int len, input logic [7:0] d, input bit rep);
    src_on[i]   = 1'b1;
    src_rem[i]  = len;
    src_flen[i] = len;
    src_data[i] = d;
    src_rep[i]  = rep;
  endtask

  task automatic advance(input int i);
    src_data[i] = src_data[i] + 8'd1;
    src_rem[i]  = src_rem[i] - 1;
    if (src_rem[i] == 0 && src_rep[i]) src_rem[i] = src_flen[i];
  endtask

  task automatic clr_log();
    st_cyc.delete();
    st_dat.delete();
    st_own.delete();
    rdy0_cnt = 0;
    rdy1_cnt = 0;
    saw_idle = 1'b0;
  endtask

  // One clock: sample at negedge, then update stimulus just after posedge
  task automatic step();
    @(negedge clk);
    s_start = tx_start;
    hs0 = req0_ready;
    hs1 = req1_ready;
    if (hs0) rdy0_cnt++;
    if (hs1) rdy1_cnt++;
    if ((hs0 && hs1) || (hs0 && !grant[0]) || (hs1 && !grant[1]) ||
        (tx_start && grant == 2'b00))
      inv_bad++;
    if (grant == 2'b00) saw_idle = 1'b1;
    if (tx_start) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(tx_data);
      st_own.push_back(grant);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs0) advance(0);
    if (hs1) advance(1);
    drive();
    if (auto_en) begin
      tx_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) tx_done = 1'b1;
      end else if (s_start) begin
        done_cnt = done_del;
      end
    end
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    src_on[0] = 1'b0;
    src_on[1] = 1'b0;
    drive();
    tx_done  = 1'b0;
    auto_en  = 1'b0;
    done_cnt = 0;
    #1;
    chk({name, "_grant"},  32'(grant), 32'h0);
    chk({name, "_start"},  32'(tx_start), 32'h0);
    chk({name, "_data"},   32'(tx_data), 32'h0);
    chk({name, "_ready0"}, 32'(req0_ready), 32'h0);
    chk({name, "_ready1"}, 32'(req1_ready), 32'h0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    chk({name, "_starts"}, st_cyc.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (grant != 2'b00 && k < budget) begin
      step();
      k++;
    end
    chk({name, "_idle"}, 32'(grant), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0;
    logic [1:0] eo;
    logic [7:0] ed;

    // {v0, v1, d0, d1, expected grant, expected byte}; rr pointer starts at req0
    vt[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 2'b01, 8'hA5};
    vt[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 2'b01, 8'h3C};
    vt[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 2'b10, 8'h22};
    vt[3] = '{1'b1, 1'b1, 8'h44, 8'h55, 2'b01, 8'h44};
    vt[4] = '{1'b0, 1'b1, 8'h00, 8'h66, 2'b10, 8'h66};
    vt[5] = '{1'b0, 1'b1, 8'h00, 8'h77, 2'b10, 8'h77};
    vt[6] = '{1'b1, 1'b1, 8'h88, 8'h99, 2'b01, 8'h88};

    src_rem[0] = 0; src_rem[1] = 0;
    src_data[0] = 8'h00; src_data[1] = 8'h00;
    do_reset("rst");

    // Single-byte arbitration vectors
    for (int i = 0; i < 7; i++) begin
      clr_log();
      if (vt[i].v0) src_frame(0, 1, vt[i].d0, 1'b0);
      if (vt[i].v1) src_frame(1, 1, vt[i].d1, 1'b0);
      drive();
      n = 0;
      step();
      while (!s_start && n < 20) begin
        n++;
        step();
      end
      chk($sformatf("vec%0d_latency", i), n, 2);
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].exp_grant));
      chk($sformatf("vec%0d_rdy0", i), rdy0_cnt, 32'(vt[i].exp_grant[0]));
      chk($sformatf("vec%0d_rdy1", i), rdy1_cnt, 32'(vt[i].exp_grant[1]));
      src_on[0] = 1'b0;
      src_on[1] = 1'b0;
      drive();
      repeat (5) step();
      chk($sformatf("vec%0d_data_held", i), 32'(tx_data), 32'(vt[i].exp_data));
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      chk($sformatf("vec%0d_released", i), 32'(grant), 32'h0);
      repeat (100) step();
    end

    // 3-byte frame: launches exactly 96 cycles apart, grant held throughout
    clr_log();
    src_frame(0, 3, 8'hC0, 1'b0);
    drive();
    auto_en = 1'b1;
    wait_starts(1, 20, "t2a");
    saw_idle = 1'b0;
    wait_starts(3, 400, "t2b");
    chk("t2_grant_held", 32'(saw_idle), 32'h0);
    if (st_cyc.size() >= 3) begin
      chk("t2_gap1", st_cyc[1] - st_cyc[0], 96);
      chk("t2_gap2", st_cyc[2] - st_cyc[1], 96);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t2_data%0d", k), 32'(st_dat[k]), 32'(8'hC0 + k));
        chk($sformatf("t2_own%0d", k), 32'(st_own[k]), 32'h1);
      end
    end
    wait_idle(50, "t2");

    // Continuous long frames on both sides: 16-byte bursts alternate
    do_reset("t3_rst");
    clr_log();
    src_frame(0, 40, 8'h00, 1'b1);
    src_frame(1, 40, 8'h80, 1'b1);
    drive();
    auto_en = 1'b1;
    wait_starts(48, 5200, "t3");
    for (int k = 0; k < 48 && k < st_cyc.size(); k++) begin
      eo = ((k / 16) % 2 == 1) ? 2'b10 : 2'b01;
      ed = (eo == 2'b10) ? 8'(8'h80 + (k % 16)) : 8'(((k / 32) * 16) + (k % 16));
      chk($sformatf("t3_own%0d", k), 32'(st_own[k]), 32'(eo));
      chk($sformatf("t3_data%0d", k), 32'(st_dat[k]), 32'(ed));
      if (k > 0) chk($sformatf("t3_gap%0d", k), st_cyc[k] - st_cyc[k-1], 96);
    end
    chk("t3_rdy0_cnt", rdy0_cnt, 32);
    chk("t3_rdy1_cnt", rdy1_cnt, 16);

    // Both valid from reset: req0 first, req1 after req0's last byte
    do_reset("t4_rst");
    clr_log();
    src_frame(0, 2, 8'h10, 1'b1);
    src_frame(1, 2, 8'h20, 1'b1);
    drive();
    c0 = cyc;
    auto_en = 1'b1;
    wait_starts(5, 700, "t4");
    if (st_cyc.size() >= 5) begin
      chk("t4_first_latency", st_cyc[0] - c0, 2);
      chk("t4_own0", 32'(st_own[0]), 32'h1);
      chk("t4_own1", 32'(st_own[1]), 32'h1);
      chk("t4_own2", 32'(st_own[2]), 32'h2);
      chk("t4_own3", 32'(st_own[3]), 32'h2);
      chk("t4_own4", 32'(st_own[4]), 32'h1);
      chk("t4_data1", 32'(st_dat[1]), 32'h11);
      chk("t4_data2", 32'(st_dat[2]), 32'h20);
      chk("t4_data4", 32'(st_dat[4]), 32'h12);
    end

    // Reset between tx_start and tx_done
    do_reset("t5_pre");
    clr_log();
    src_frame(0, 1, 8'h5A, 1'b0);
    drive();
    wait_starts(1, 20, "t5a");
    repeat (3) step();
    chk("t5_data_before", 32'(tx_data), 32'h5A);
    chk("t5_grant_before", 32'(grant), 32'h1);
    do_reset("t5_mid");
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (5) step();
    chk("t5_no_reissue", st_cyc.size(), 1);
    chk("t5_idle_after", 32'(grant), 32'h0);
    src_frame(1, 1, 8'hB7, 1'b0);
    drive();
    c0 = cyc;
    wait_starts(2, 20, "t5b");
    if (st_cyc.size() >= 2) begin
      chk("t5_immediate", st_cyc[1] - c0, 2);
      chk("t5_data", 32'(st_dat[1]), 32'hB7);
      chk("t5_own", 32'(st_own[1]), 32'h2);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wait_idle(10, "t5");

    // Owner drops valid mid-frame; spurious tx_done while idle
    do_reset("t6_rst");
    clr_log();
    src_frame(0, 3, 8'h30, 1'b0);
    src_frame(1, 1, 8'h60, 1'b0);
    drive();
    auto_en = 1'b1;
    wait_starts(1, 20, "t6a");
    src_on[0] = 1'b0;
    drive();
    saw_idle = 1'b0;
    wait_starts(2, 300, "t6b");
    chk("t6_released", 32'(saw_idle), 32'h1);
    chk("t6_rdy0_cnt", rdy0_cnt, 1);
    if (st_cyc.size() >= 2) begin
      chk("t6_own0", 32'(st_own[0]), 32'h1);
      chk("t6_own1", 32'(st_own[1]), 32'h2);
      chk("t6_data1", 32'(st_dat[1]), 32'h60);
    end
    wait_idle(50, "t6");
    auto_en = 1'b0;
    tx_done = 1'b0;
    repeat (3) begin
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
    end
    chk("t6_no_start_idle", st_cyc.size(), 2);
    chk("t6_grant_idle", 32'(grant), 32'h0);

    chk("invariants", inv_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
